// File: rtl/spart_pkg.sv
// Shared constants and state encoding for the SPART transmit scheduler.
// Holds the transmitter bus encodings and the scheduler FSM state type.
package spart_pkg;

  localparam logic [1:0] IOADDR_TX = 2'b00;
  localparam logic       IORW_WR   = 1'b0;
  localparam logic       IORW_RD   = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } sched_state_t;

endpackage

// File: rtl/spart_tx_sched_rr_arb.sv
// Combinational round-robin picker: first request at or after ptr_i, wrapping to 0.
// Zero latency; no state, the caller owns the pointer.
module spart_rr_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o,
  output logic            vld_o
);

  // First pass covers ptr..NREQ-1, second pass covers the wrapped part 0..ptr-1.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!vld_o && req_i[i] && (i >= int'(ptr_i))) begin
        vld_o    = 1'b1;
        gnt_o[i] = 1'b1;
        idx_o    = IDW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!vld_o && req_i[i]) begin
        vld_o    = 1'b1;
        gnt_o[i] = 1'b1;
        idx_o    = IDW'(i);
      end
    end
  end

endmodule

// File: rtl/spart_tx_sched.sv
// Round-robin scheduler sharing one SPART transmitter among NREQ byte producers.
// Accept in IDLE (Mealy ready), strobe next cycle, then hold off until TBR drops and returns high.
module spart_tx_sched #(
  parameter int NREQ        = 4,
  parameter int IDW         = $clog2(NREQ),
  parameter int LOCK_MSG    = 1,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid_i,
  input  logic [8*NREQ-1:0] req_data_i,
  input  logic [NREQ-1:0]   req_last_i,
  output logic [NREQ-1:0]   req_ready_o,
  input  logic              tx_tbr_i,
  output logic [7:0]        tx_data_o,
  output logic [1:0]        tx_ioaddr_o,
  output logic              tx_iorw_o,
  output logic [IDW-1:0]    grant_id_o,
  output logic              busy_o,
  output logic              err_o,
  input  logic              err_clr_i
);

  import spart_pkg::*;

  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  sched_state_t    state_q, state_d;
  logic [7:0]      data_q, data_d;
  logic            last_q, last_d;
  logic [IDW-1:0]  grant_q, grant_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic            lock_q, lock_d;
  logic            err_q, err_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] arb_gnt;
  logic [IDW-1:0]  arb_idx;
  logic            arb_vld;
  logic [IDW-1:0]  ptr_inc;

  // A locked message restricts arbitration to the current owner only.
  always_comb begin
    elig = req_valid_i;
    if (lock_q) elig = req_valid_i & (NREQ'(1) << grant_q);
  end

  assign ptr_inc = (grant_q == IDW'(NREQ - 1)) ? '0 : grant_q + 1'b1;

  spart_rr_arb #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req_i (elig),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .vld_o (arb_vld)
  );

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    last_d      = last_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    lock_d      = lock_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    req_ready_o = '0;
    tx_iorw_o   = IORW_RD;

    if (err_clr_i) err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (tx_tbr_i && arb_vld) begin
          req_ready_o = arb_gnt;
          grant_d     = arb_idx;
          for (int i = 0; i < NREQ; i++) begin
            if (arb_gnt[i]) begin
              data_d = req_data_i[8*i +: 8];
              last_d = req_last_i[i];
            end
          end
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        tx_iorw_o = IORW_WR;
        cnt_d     = '0;
        state_d   = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (!tx_tbr_i) begin
          state_d = S_WAIT_DONE;
        end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
          // Transmitter never took the byte: flag it and release the bus to the others.
          err_d   = 1'b1;
          lock_d  = 1'b0;
          ptr_d   = ptr_inc;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (tx_tbr_i) begin
          state_d = S_IDLE;
          if ((LOCK_MSG != 0) && !last_q) begin
            lock_d = 1'b1;
          end else begin
            lock_d = 1'b0;
            ptr_d  = ptr_inc;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      data_q  <= 8'h00;
      last_q  <= 1'b0;
      grant_q <= '0;
      ptr_q   <= '0;
      lock_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      lock_q  <= lock_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign tx_data_o   = data_q;
  assign tx_ioaddr_o = IOADDR_TX;
  assign grant_id_o  = grant_q;
  assign busy_o      = (state_q != S_IDLE) || lock_q;
  assign err_o       = err_q;

endmodule
